// File: rtl/regfile_wport_sched.sv
// regfile_wport_sched: arbitrates WB and LINK writes onto one registered regfile write port through an in-order pending FIFO.
// Define RF_FWD_EN to forward buffered/in-flight write data to rs1/rs2; otherwise the fwd outputs are tied to zero.
module regfile_wport_sched #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 wb_ready,
    input  logic                 lk_valid,
    input  logic [AW-1:0]        lk_rd,
    input  logic [XLEN-1:0]      lk_pc,
    output logic                 lk_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [(1<<AW)-1:0]   pend_mask,
    output logic                 busy,
    input  logic [AW-1:0]        rs1,
    input  logic [AW-1:0]        rs2,
    output logic                 fwd1_hit,
    output logic [XLEN-1:0]      fwd1_data,
    output logic                 fwd2_hit,
    output logic [XLEN-1:0]      fwd2_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DC = CW'(DEPTH);

    logic [AW-1:0]   rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [PW-1:0]   head, tail, lk_slot, tail_n;
    logic [CW-1:0]   count;
    logic            head_v, wb_acc, lk_acc, wb_push, lk_push, issue;
    logic [AW-1:0]   iss_rd;
    logic [XLEN-1:0] iss_data, lk_data;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] slot(input logic [PW-1:0] h, input int i);
        int k;
        k = int'(h) + i;
        return PW'((k >= DEPTH) ? k - DEPTH : k);
    endfunction

    assign wb_ready = count < DC;
    assign lk_ready = count < DC - 1'b1;
    assign lk_data  = lk_pc + XLEN'(4);
    assign head_v   = count != '0;
    assign wb_acc   = wb_valid && wb_ready && wb_rd != '0;
    assign lk_acc   = lk_valid && lk_ready && lk_rd != '0;
    // The head always drains first, so new requests queue behind it in WB-then-LINK order.
    assign wb_push  = wb_acc && head_v;
    assign lk_push  = lk_acc && (head_v || wb_acc);
    assign issue    = head_v || wb_acc || lk_acc;
    assign iss_rd   = head_v ? rd_q[head] : wb_acc ? wb_rd : lk_rd;
    assign iss_data = head_v ? data_q[head] : wb_acc ? wb_data : lk_data;
    assign lk_slot  = wb_push ? inc(tail) : tail;
    assign tail_n   = lk_push ? inc(lk_slot) : wb_push ? inc(tail) : tail;
    assign busy     = head_v || rf_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (wb_push) begin
                rd_q[tail]   <= wb_rd;
                data_q[tail] <= wb_data;
            end
            if (lk_push) begin
                rd_q[lk_slot]   <= lk_rd;
                data_q[lk_slot] <= lk_data;
            end
            head  <= head_v ? inc(head) : head;
            tail  <= tail_n;
            count <= count + CW'(wb_push) + CW'(lk_push) - CW'(head_v);
            rf_we <= issue;
            if (issue) begin
                rf_waddr <= iss_rd;
                rf_wdata <= iss_data;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i < int'(count)) pend_mask[rd_q[slot(head, i)]] = 1'b1;
        if (rf_we) pend_mask[rf_waddr] = 1'b1;
        pend_mask[0] = 1'b0;
    end

`ifdef RF_FWD_EN
    // Scan oldest to youngest so the last match (tail-most) wins over rf_wdata.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
        logic [XLEN:0] r;
        r = (rf_we && rf_waddr == rs) ? {1'b1, rf_wdata} : '0;
        for (int i = 0; i < DEPTH; i++)
            if (i < int'(count) && rd_q[slot(head, i)] == rs) r = {1'b1, data_q[slot(head, i)]};
        return (rs == '0) ? '0 : r;
    endfunction

    assign {fwd1_hit, fwd1_data} = lookup(rs1);
    assign {fwd2_hit, fwd2_data} = lookup(rs2);
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wport_sched.sv
// tb_regfile_wport_sched: random and directed stimulus against a queue-based model of the write-port scheduler.
module tb_regfile_wport_sched;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    logic              clk = 1'b0;
    logic              rst_n, wb_valid, lk_valid;
    logic [AW-1:0]     wb_rd, lk_rd, rs1, rs2, rf_waddr;
    logic [XLEN-1:0]   wb_data, lk_pc, rf_wdata, fwd1_data, fwd2_data;
    logic              wb_ready, lk_ready, rf_we, busy, fwd1_hit, fwd2_hit;
    logic [(1<<AW)-1:0] pend_mask;

    regfile_wport_sched #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .lk_valid(lk_valid), .lk_rd(lk_rd), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .busy(busy),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t             mq[$];
    logic            m_we;
    logic [AW-1:0]   m_waddr;
    logic [XLEN-1:0] m_wdata;
    bit              m_ok = 0;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN:0] m_fwd(input logic [AW-1:0] rs);
        logic [XLEN:0] r;
        r = (m_we && m_waddr == rs) ? {1'b1, m_wdata} : '0;
        foreach (mq[i]) if (mq[i].rd == rs) r = {1'b1, mq[i].data};
        return (rs == '0) ? '0 : r;
    endfunction

    task automatic model_chk();
        logic [(1<<AW)-1:0] pm;
        logic [XLEN:0] f1, f2;
        if (!m_ok) return;
        pm = '0;
        foreach (mq[i]) pm[mq[i].rd] = 1'b1;
        if (m_we) pm[m_waddr] = 1'b1;
        pm[0] = 1'b0;
`ifdef RF_FWD_EN
        f1 = m_fwd(rs1);
        f2 = m_fwd(rs2);
`else
        f1 = '0;
        f2 = '0;
`endif
        chk("rf_we", rf_we, m_we);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("wb_ready", wb_ready, mq.size() < DEPTH);
        chk("lk_ready", lk_ready, mq.size() < DEPTH - 1);
        chk("pend_mask", pend_mask, pm);
        chk("busy", busy, mq.size() != 0 || m_we);
        chk("fwd1", {fwd1_hit, fwd1_data}, f1);
        chk("fwd2", {fwd2_hit, fwd2_data}, f2);
    endtask

    // Acceptance order is issue order: new requests join the back of the pending queue, one write leaves per cycle.
    task automatic model_upd();
        int  n;
        wr_t e;
        if (!rst_n) begin
            mq.delete();
            m_we = 0;
            m_waddr = '0;
            m_wdata = '0;
            m_ok = 1;
            return;
        end
        if (!m_ok) return;
        n = mq.size();
        if (wb_valid && n < DEPTH && wb_rd != 0) mq.push_back({wb_rd, wb_data});
        if (lk_valid && n < DEPTH - 1 && lk_rd != 0) mq.push_back({lk_rd, lk_pc + 32'd4});
        if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1;
            m_waddr = e.rd;
            m_wdata = e.data;
        end else
            m_we = 0;
    endtask

    task automatic cyc(input logic r, input logic wv, input logic [AW-1:0] wrd, input logic [XLEN-1:0] wd,
                       input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] lpc);
        rst_n = r;
        wb_valid = wv;
        wb_rd = wrd;
        wb_data = wd;
        lk_valid = lv;
        lk_rd = lrd;
        lk_pc = lpc;
        rs1 = AW'($urandom_range(0, 7));
        rs2 = AW'($urandom_range(0, 7));
        @(negedge clk);
        model_chk();
        model_upd();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        idle();
        // Lone WB
        cyc(1, 1, 5, 32'h1234, 0, 0, 0);
        chk("lone_we", rf_we, 1);
        chk("lone_addr", rf_waddr, 5);
        chk("lone_data", rf_wdata, 32'h1234);
        idle();
        chk("lone_we_off", rf_we, 0);
        // Collision: WB issues now, LINK waits one cycle
        cyc(1, 1, 3, 32'hAA, 1, 1, 32'h100);
        chk("col_addr0", rf_waddr, 3);
        chk("col_data0", rf_wdata, 32'hAA);
        chk("col_pend1", pend_mask[1], 1);
        idle();
        chk("col_addr1", rf_waddr, 1);
        chk("col_data1", rf_wdata, 32'h104);
        idle();
        // Backpressure: LINK refused while one entry is buffered
        cyc(1, 1, 10, 32'h10, 1, 11, 32'h20);
        chk("bp_lk_ready", lk_ready, 0);
        chk("bp_w0", {rf_waddr, rf_wdata}, {5'd10, 32'h10});
        cyc(1, 1, 12, 32'h30, 1, 13, 32'h40);
        chk("bp_w1", {rf_waddr, rf_wdata}, {5'd11, 32'h24});
        cyc(1, 1, 14, 32'h50, 1, 15, 32'h60);
        chk("bp_w2", {rf_waddr, rf_wdata}, {5'd12, 32'h30});
        idle();
        chk("bp_w3", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd14, 32'h50});
        idle();
        chk("bp_done", rf_we, 0);
        // x0 request is dropped, LINK goes straight through
        cyc(1, 1, 0, 32'h99, 1, 2, 32'h0);
        chk("x0_w", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd2, 32'h4});
        chk("x0_pend", pend_mask, 32'h4);
        idle();
        chk("x0_busy", busy, 0);
        // pc+4 wraps
        cyc(1, 0, 0, 0, 1, 9, 32'hFFFF_FFFC);
        chk("wrap_w", {rf_waddr, rf_wdata}, {5'd9, 32'h0});
        idle();
        // Reset while buffered work is pending
        cyc(1, 1, 4, 32'h1, 1, 6, 32'h2);
        chk("rst_pre_busy", busy, 1);
        cyc(0, 1, 20, 32'h7, 1, 21, 32'h8);
        chk("rst_we", rf_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_ready", {wb_ready, lk_ready}, 2'b11);
        idle();
        chk("rst_discard", rf_we, 0);
`ifdef RF_FWD_EN
        cyc(1, 1, 7, 32'h11, 1, 7, 32'h51);
        rs1 = 7;
        rs2 = 0;
        #1;
        chk("fwd1_hit", fwd1_hit, 1);
        chk("fwd1_data", fwd1_data, 32'h55);
        chk("fwd2_hit", fwd2_hit, 0);
        idle();
`endif
        for (int i = 0; i < 3000; i++) begin
            logic [XLEN-1:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom(),
                ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), pc);
        end
        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
